cp0_exc_arbiter: RTL

//  Exception/interrupt sequencer in front of CP0. Arbitrates the WB-stage exception, ERET and

---
 rtl/cp0_exc_arbiter_pkg.sv | 30 +++
 rtl/cp0_exc_arbiter_if.sv | 48 ++++
 rtl/cp0_int_sync.sv | 30 +++
 rtl/cp0_exc_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cp0_exc_arbiter_pkg.sv
// Shared definitions for the CP0 exception/interrupt sequencer: exception codes,
// default exception vector, FSM state encoding and small helper functions.
package cp0_exc_arbiter_pkg;

    localparam logic [4:0]  EXC_INT  = 5'h00;
    localparam logic [4:0]  EXC_ADEL = 5'h04;
    localparam logic [4:0]  EXC_ADES = 5'h05;
    localparam logic [4:0]  EXC_SYS  = 5'h08;
    localparam logic [4:0]  EXC_BP   = 5'h09;
    localparam logic [4:0]  EXC_RI   = 5'h0a;
    localparam logic [4:0]  EXC_OV   = 5'h0c;

    localparam logic [31:0] EX_ENTRY_DEFAULT = 32'hbfc00380;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } arb_state_e;

    // A delay-slot instruction reports the branch PC so the branch re-executes.
    function automatic logic [31:0] calc_epc(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_exc_arbiter_if.sv
// Signal bundle between the exception sequencer and its WB / CP0 / IF neighbours.
// The slave modport is the sequencer's view; master is the surrounding pipeline.
interface cp0_exc_arbiter_if;

    logic        ws_valid;
    logic        ws_ex;
    logic [4:0]  ws_excode;
    logic        ws_eret;
    logic        ws_bd;
    logic [31:0] ws_pc;
    logic [31:0] ws_badvaddr;
    logic [5:0]  hw_int;
    logic [7:0]  cp0_status_im;
    logic        cp0_status_ie;
    logic        cp0_status_exl;
    logic [1:0]  cp0_cause_ip_sw;
    logic [31:0] cp0_epc;
    logic        timer_int;
    logic        wb_ex;
    logic        eret_flush;
    logic [4:0]  ex_excode;
    logic        ex_bd;
    logic [31:0] ex_epc;
    logic        ex_badvaddr_we;
    logic [31:0] ex_badvaddr;
    logic [5:0]  cause_ip_hw;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport slave (
        input  ws_valid, ws_ex, ws_excode, ws_eret, ws_bd, ws_pc, ws_badvaddr,
        input  hw_int, cp0_status_im, cp0_status_ie, cp0_status_exl,
        input  cp0_cause_ip_sw, cp0_epc, timer_int, redirect_ready,
        output wb_ex, eret_flush, ex_excode, ex_bd, ex_epc, ex_badvaddr_we,
        output ex_badvaddr, cause_ip_hw, flush, redirect_valid, redirect_pc
    );

    modport master (
        output ws_valid, ws_ex, ws_excode, ws_eret, ws_bd, ws_pc, ws_badvaddr,
        output hw_int, cp0_status_im, cp0_status_ie, cp0_status_exl,
        output cp0_cause_ip_sw, cp0_epc, timer_int, redirect_ready,
        input  wb_ex, eret_flush, ex_excode, ex_bd, ex_epc, ex_badvaddr_we,
        input  ex_badvaddr, cause_ip_hw, flush, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/cp0_int_sync.sv
// Multi-flop synchroniser for the asynchronous hardware interrupt lines.
module cp0_int_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] chain_r [STAGES];

    // Shift each interrupt bit through STAGES flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            chain_r[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain_r[i] <= chain_r[i-1];
            end
        end
    end

    assign dout = chain_r[STAGES-1];

endmodule

// File: rtl/cp0_exc_arbiter.sv
// Exception/interrupt sequencer in front of CP0: arbitrates WB events, emits the
// one-cycle CP0 commit strobes, holds the flush, then offers the redirect PC to fetch.
module cp0_exc_arbiter
    import cp0_exc_arbiter_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] EX_ENTRY     = EX_ENTRY_DEFAULT,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic                clk,
    input  logic                reset,
    cp0_exc_arbiter_if.slave    arb
);

    localparam logic [7:0] CNT_INIT = 8'(FLUSH_CYCLES - 1);

    arb_state_e  state_r;
    logic [7:0]  cnt_r;
    logic [31:0] redirect_pc_r;
    logic        redirect_valid_r;
    logic        flush_hold_r;

    logic [5:0]  sync_hw_s;
    logic [7:0]  ip_s;
    logic        int_req_s;
    logic        accept_s;
    logic        take_exc_s;
    logic        take_eret_s;
    logic        badv_we_s;

    cp0_int_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (6)
    ) u_int_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (arb.hw_int),
        .dout   (sync_hw_s)
    );

    // Interrupt pending evaluation and arbitration (interrupt > exception > ERET).
    always_comb begin
        ip_s        = {(arb.timer_int | sync_hw_s[5]), sync_hw_s[4:0], arb.cp0_cause_ip_sw};
        int_req_s   = arb.cp0_status_ie & ~arb.cp0_status_exl & (|(ip_s & arb.cp0_status_im));
        // Gated by reset so nothing leaks out combinationally while held in reset.
        accept_s    = ~reset & (state_r == ST_IDLE) & arb.ws_valid
                      & (int_req_s | arb.ws_ex | arb.ws_eret);
        take_exc_s  = accept_s & (int_req_s | arb.ws_ex);
        take_eret_s = accept_s & ~take_exc_s;
        badv_we_s   = take_exc_s & ~int_req_s & is_addr_exc(arb.ws_excode);
    end

    // Same-cycle CP0 commit data and strobes.
    always_comb begin
        arb.wb_ex          = take_exc_s;
        arb.eret_flush     = take_eret_s;
        arb.flush          = accept_s | flush_hold_r;
        arb.redirect_valid = redirect_valid_r;
        arb.redirect_pc    = redirect_pc_r;
        arb.ex_badvaddr_we = badv_we_s;
        arb.cause_ip_hw    = reset ? 6'd0 : ip_s[7:2];
        if (take_exc_s) begin
            arb.ex_excode = int_req_s ? EXC_INT : arb.ws_excode;
            arb.ex_bd     = arb.ws_bd;
            arb.ex_epc    = calc_epc(arb.ws_pc, arb.ws_bd);
        end else begin
            arb.ex_excode = 5'd0;
            arb.ex_bd     = 1'b0;
            arb.ex_epc    = 32'd0;
        end
        if (badv_we_s) begin
            arb.ex_badvaddr = arb.ws_badvaddr;
        end else begin
            arb.ex_badvaddr = 32'd0;
        end
    end

    // Sequencer FSM: IDLE -> FLUSH (optional) -> REDIRECT -> IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            cnt_r            <= 8'd0;
            redirect_pc_r    <= 32'd0;
            redirect_valid_r <= 1'b0;
            flush_hold_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        redirect_pc_r <= take_exc_s ? EX_ENTRY : arb.cp0_epc;
                        cnt_r         <= CNT_INIT;
                        if (FLUSH_CYCLES > 1) begin
                            state_r      <= ST_FLUSH;
                            flush_hold_r <= 1'b1;
                        end else begin
                            state_r          <= ST_REDIRECT;
                            redirect_valid_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    // <= guards against a stuck counter ever reaching zero here.
                    if (cnt_r <= 8'd1) begin
                        state_r          <= ST_REDIRECT;
                        cnt_r            <= 8'd0;
                        flush_hold_r     <= 1'b0;
                        redirect_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_REDIRECT: begin
                    if (arb.redirect_ready) begin
                        state_r          <= ST_IDLE;
                        redirect_valid_r <= 1'b0;
                    end else begin
                        state_r <= ST_REDIRECT;
                    end
                end
                default: begin
                    state_r          <= ST_IDLE;
                    cnt_r            <= 8'd0;
                    flush_hold_r     <= 1'b0;
                    redirect_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
